excp_redirect_ctrl: RTL and testbench
=====================================

EXCP_REDIRECT_CTRL -- requirements
Module: excp_redirect_ctrl

Interface
REQ-001 SHALL have parameter OUTSTANDING_MAX, default 4, meaning the maximum number of in-flight instruction-fetch reads (1..7).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port flush_i  input  1  exception/ERET flush pulse from CP0.
REQ-005 SHALL have port epc_i  input  32  handler or return PC from CP0, valid with flush_i.
REQ-006 SHALL have port stallreq_if_i / stallreq_ex_i / stallreq_mem_i  input  1 each  per-stage stall requests.
REQ-007 SHALL have port ifetch_req_i  input  1  fetch read-address handshake fired this cycle.
REQ-008 SHALL have port ifetch_resp_i  input  1  fetch read-data last beat fired this cycle.
REQ-009 SHALL have port redirect_ack_i  input  1  IF stage accepted new_pc_o.
REQ-010 SHALL have port stall_o  output  6  stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-011 SHALL have port flush_o  output  1  pipeline flush, one-cycle pulse.
REQ-012 SHALL have port new_pc_o  output  32  redirect target.
REQ-013 SHALL have port redirect_valid_o  output  1  new_pc_o valid, held until acked.
REQ-014 SHALL have port discard_o  output  1  IF shall drop returning fetch data.
REQ-015 SHALL have port busy_o  output  1  FSM not IDLE.

Function
REQ-016 SHALL keep an outstanding counter, width 3: +1 on ifetch_req_i only, -1 on ifetch_resp_i only, unchanged on both or neither; decrement at 0 ignored; increment at OUTSTANDING_MAX ignored.
REQ-017 SHALL form the base stall vector combinationally with priority mem > ex > if: mem -> 6'b011111, ex -> 6'b001111, if -> 6'b000011, none -> 6'b000000.
REQ-018 SHALL OR 6'b000011 into stall_o when the counter equals OUTSTANDING_MAX, or when state is DRAIN or REDIRECT.
REQ-019 SHALL implement FSM states IDLE, DRAIN, REDIRECT.
REQ-020 SHALL, on flush_i in any state, register new_pc_o <= epc_i and flush_o <= 1 for exactly the next cycle, and enter DRAIN if the next counter value is nonzero, else REDIRECT.
REQ-021 SHALL, in DRAIN without flush_i, move to REDIRECT in the cycle the next counter value reaches 0.
REQ-022 SHALL, in REDIRECT without flush_i, hold redirect_valid_o = 1 and new_pc_o stable until redirect_ack_i, then return to IDLE the next cycle.
REQ-023 SHALL drive discard_o = 1 exactly when state is DRAIN, redirect_valid_o = 1 exactly when state is REDIRECT, and busy_o = 1 exactly when state is not IDLE.
REQ-024 SHALL give flush_i priority over redirect_ack_i and DRAIN completion in the same cycle; the newest epc_i wins.
REQ-025 SHALL keep counting ifetch_req_i fired in DRAIN (an IF protocol violation) and extend DRAIN accordingly.

Reset
REQ-026 SHALL on rst set state IDLE, counter 0, stall_o 0, flush_o 0, new_pc_o 32'h0, redirect_valid_o 0, discard_o 0, busy_o 0.
REQ-027 SHALL let rst override all other inputs in the same cycle, including rst asserted mid-DRAIN or mid-REDIRECT.

Configuration
REQ-028 SHALL, with STALL_PERF_CNT_EN defined, add output perf_stall_cnt_o (32 bits); it resets to 0, increments each cycle stall_o != 0, and wraps 32'hFFFFFFFF -> 0.
REQ-029 SHALL, without STALL_PERF_CNT_EN, omit the port perf_stall_cnt_o and its counter entirely.

Verification
REQ-030 SHALL cover: counter 0, flush_i with epc_i=32'hBFC00380 -> next cycle flush_o=1, state REDIRECT, new_pc_o=32'hBFC00380; ack 3 cycles later -> IDLE.
REQ-031 SHALL cover: 2 outstanding, flush_i -> DRAIN with discard_o=1 and stall_o[1:0]=2'b11; two resp pulses -> REDIRECT the cycle after the second.
REQ-032 SHALL cover: stallreq_mem_i=1 with stallreq_if_i=1 -> stall_o=6'b011111; only stallreq_ex_i=1 -> stall_o=6'b001111.
REQ-033 SHALL cover: 4 reqs, no resps -> stall_o=6'b000011; simultaneous req+resp at 4 -> counter stays 4.
REQ-034 SHALL cover: in REDIRECT, flush_i(32'h80001000) with redirect_ack_i in the same cycle -> new_pc_o=32'h80001000, flush_o pulses, stays REDIRECT.
REQ-035 SHALL cover: rst during DRAIN -> all outputs 0 next cycle and counter 0.

Source files
------------

// File: rtl/excp_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// excp_redirect_ctrl
//
// Purpose:
//   Sequences the pipeline redirect that follows an exception or ERET flush
//   from CP0. It counts in-flight instruction-fetch reads. When a flush
//   arrives, it drains those reads and tells IF to discard their data. It
//   then presents the new PC until IF accepts it. It also merges the
//   per-stage stall requests into the pipeline stall vector.
//
// Optional feature:
//   Define STALL_PERF_CNT_EN to add perf_stall_cnt_o. This is a free-running
//   32-bit count of cycles in which stall_o is nonzero.
//
// Ports:
//   clk               in   clock, rising edge
//   rst               in   synchronous active-high reset
//   flush_i           in   exception/ERET flush pulse
//   epc_i      [31:0] in   redirect target, valid with flush_i
//   stallreq_if_i     in   IF stage stall request
//   stallreq_ex_i     in   EX stage stall request
//   stallreq_mem_i    in   MEM stage stall request
//   ifetch_req_i      in   fetch read-address handshake fired
//   ifetch_resp_i     in   fetch read-data last beat fired
//   redirect_ack_i    in   IF accepted new_pc_o
//   stall_o     [5:0] out  stall vector {wb,mem,ex,id,if,pc}
//   flush_o           out  one-cycle pipeline flush
//   new_pc_o   [31:0] out  redirect target
//   redirect_valid_o  out  new_pc_o valid, held until acked
//   discard_o         out  IF drops returning fetch data
//   busy_o            out  controller not idle
//   perf_stall_cnt_o  out  stalled-cycle count (STALL_PERF_CNT_EN only)
//
// FSM states:
//   state       | meaning
//   ST_IDLE     | normal operation, no redirect pending
//   ST_DRAIN    | flush seen, waiting for in-flight fetches to return
//   ST_REDIRECT | fetches drained, new_pc_o offered until acked
// ---------------------------------------------------------------------------
module excp_redirect_ctrl #(
  parameter int unsigned OUTSTANDING_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] epc_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        ifetch_req_i,
  input  logic        ifetch_resp_i,
  input  logic        redirect_ack_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        redirect_valid_o,
  output logic        discard_o,
  output logic        busy_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam logic [2:0] CNT_MAX = 3'(OUTSTANDING_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic [5:0]  w_stall_base;

  // Outstanding fetch counter. A simultaneous req and resp cancel out.
  // The count saturates at both ends.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (ifetch_req_i && !ifetch_resp_i && (r_cnt != CNT_MAX))
      w_cnt_nxt = r_cnt + 3'd1;
    else if (ifetch_resp_i && !ifetch_req_i && (r_cnt != 3'd0))
      w_cnt_nxt = r_cnt - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_flush  <= 1'b0;
      r_new_pc <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flush <= flush_i;
      if (flush_i)
        r_new_pc <= epc_i;
    end
  end

  // A new flush always restarts the sequence with the newest target. It
  // takes precedence over a same-cycle ack or drain completion.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = (w_cnt_nxt != 3'd0) ? ST_DRAIN : ST_REDIRECT;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_IDLE;
        ST_DRAIN:    if (w_cnt_nxt == 3'd0) w_state_nxt = ST_REDIRECT;
        ST_REDIRECT: if (redirect_ack_i) w_state_nxt = ST_IDLE;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall_base = 6'b000000;
    if (stallreq_mem_i)
      w_stall_base = 6'b011111;
    else if (stallreq_ex_i)
      w_stall_base = 6'b001111;
    else if (stallreq_if_i)
      w_stall_base = 6'b000011;

    stall_o = w_stall_base;
    // Freeze PC/IF while the fetch window is full or a redirect is in progress.
    if ((r_cnt == CNT_MAX) || (r_state != ST_IDLE))
      stall_o = stall_o | 6'b000011;
    // Keep the stall vector quiet while reset is asserted.
    if (rst)
      stall_o = 6'b000000;

    flush_o          = r_flush;
    new_pc_o         = r_new_pc;
    discard_o        = (r_state == ST_DRAIN);
    redirect_valid_o = (r_state == ST_REDIRECT);
    busy_o           = (r_state != ST_IDLE);
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_perf_cnt <= 32'h0;
    else if (stall_o != 6'b000000)
      r_perf_cnt <= r_perf_cnt + 32'h1;
  end

  assign perf_stall_cnt_o = r_perf_cnt;
`endif

endmodule

// File: tb/tb_excp_redirect_ctrl.sv
module tb_excp_redirect_ctrl;
  localparam int MAX = 4;

  logic        clk;
  logic        t_rst, t_flush, t_sif, t_sex, t_smem, t_req, t_resp, t_ack;
  logic [31:0] t_epc;
  logic [5:0]  stall_o;
  logic        flush_o, redirect_valid_o, discard_o, busy_o;
  logic [31:0] new_pc_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_o;
`endif

  excp_redirect_ctrl #(.OUTSTANDING_MAX(MAX)) dut (
    .clk(clk), .rst(t_rst), .flush_i(t_flush), .epc_i(t_epc),
    .stallreq_if_i(t_sif), .stallreq_ex_i(t_sex), .stallreq_mem_i(t_smem),
    .ifetch_req_i(t_req), .ifetch_resp_i(t_resp), .redirect_ack_i(t_ack),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .redirect_valid_o(redirect_valid_o), .discard_o(discard_o), .busy_o(busy_o)
`ifdef STALL_PERF_CNT_EN
    , .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the controller is doing, in behavioural terms.
  typedef enum {M_IDLE, M_DRAIN, M_REDIR} mode_t;
  mode_t       m_mode;
  int          m_cnt;
  logic        m_flush;
  logic [31:0] m_pc;
  logic [31:0] m_perf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stall depth = number of frozen stages counting from the PC end.
  function automatic logic [5:0] exp_stall();
    int n;
    n = 0;
    if (t_smem) n = 5;
    else if (t_sex) n = 4;
    else if (t_sif) n = 2;
    if ((m_cnt == MAX || m_mode != M_IDLE) && n < 2) n = 2;
    if (t_rst) n = 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic model_edge(input logic [5:0] stall_now);
    int nc;
    if (t_rst) begin
      m_cnt = 0; m_mode = M_IDLE; m_flush = 1'b0; m_pc = 32'h0; m_perf = 32'h0;
      return;
    end
    if (stall_now != 6'd0) m_perf = m_perf + 32'h1;
    nc = m_cnt;
    if (t_req && !t_resp) nc = (m_cnt < MAX) ? m_cnt + 1 : m_cnt;
    if (t_resp && !t_req) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
    m_flush = t_flush;
    if (t_flush) begin
      m_pc   = t_epc;
      m_mode = (nc != 0) ? M_DRAIN : M_REDIR;
    end else if (m_mode == M_DRAIN && nc == 0) begin
      m_mode = M_REDIR;
    end else if (m_mode == M_REDIR && t_ack) begin
      m_mode = M_IDLE;
    end
    m_cnt = nc;
  endtask

  task automatic set_in(input logic rst_v, input logic req, input logic resp,
                        input logic fl, input logic [31:0] epc, input logic ack,
                        input logic sif, input logic sex, input logic smem);
    t_rst = rst_v; t_req = req; t_resp = resp; t_flush = fl; t_epc = epc;
    t_ack = ack; t_sif = sif; t_sex = sex; t_smem = smem;
  endtask

  // Inputs are applied at the falling edge; stall_o is checked just before the
  // rising edge, registered outputs just after it.
  task automatic step();
    logic [5:0] s;
    #1;
    s = exp_stall();
    chk("stall_pre", 32'(stall_o), 32'(s));
    @(posedge clk);
    model_edge(s);
    #1;
    chk("flush_o", 32'(flush_o), 32'(m_flush));
    chk("new_pc_o", new_pc_o, m_pc);
    chk("redirect_valid_o", 32'(redirect_valid_o), 32'(m_mode == M_REDIR));
    chk("discard_o", 32'(discard_o), 32'(m_mode == M_DRAIN));
    chk("busy_o", 32'(busy_o), 32'(m_mode != M_IDLE));
    chk("stall_post", 32'(stall_o), 32'(exp_stall()));
`ifdef STALL_PERF_CNT_EN
    chk("perf_cnt", perf_stall_cnt_o, m_perf);
`endif
    @(negedge clk);
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    m_cnt = 0; m_mode = M_IDLE; m_flush = 0; m_pc = 0; m_perf = 0;
    set_in(1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    step(); step();
    chk("reset_stall", 32'(stall_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_new_pc", new_pc_o, 32'h0);

    // Flush with nothing outstanding goes straight to REDIRECT.
    set_in(0, 0, 0, 1, 32'hBFC00380, 0, 0, 0, 0); step();
    chk("s30_flush", 32'(flush_o), 32'h1);
    chk("s30_valid", 32'(redirect_valid_o), 32'h1);
    chk("s30_pc", new_pc_o, 32'hBFC00380);
    idle_in(); step(); step();
    chk("s30_flush_gone", 32'(flush_o), 32'h0);
    chk("s30_hold_pc", new_pc_o, 32'hBFC00380);
    set_in(0, 0, 0, 0, 32'h0, 1, 0, 0, 0); step();
    chk("s30_idle", 32'(busy_o), 32'h0);

    // Flush with two fetches in flight drains first.
    set_in(0, 1, 0, 0, 32'h0, 0, 0, 0, 0); step(); step();
    set_in(0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0); step();
    chk("s31_discard", 32'(discard_o), 32'h1);
    chk("s31_stall", 32'(stall_o[1:0]), 32'h3);
    set_in(0, 0, 1, 0, 32'h0, 0, 0, 0, 0); step();
    chk("s31_still_drain", 32'(discard_o), 32'h1);
    step();
    chk("s31_redirect", 32'(redirect_valid_o), 32'h1);
    set_in(0, 0, 0, 0, 32'h0, 1, 0, 0, 0); step();

    // Stall priority.
    set_in(0, 0, 0, 0, 32'h0, 0, 1, 0, 1); step();
    chk("s32_mem", 32'(stall_o), 32'h1F);
    set_in(0, 0, 0, 0, 32'h0, 0, 0, 1, 0); step();
    chk("s32_ex", 32'(stall_o), 32'h0F);
    set_in(0, 0, 0, 0, 32'h0, 0, 1, 0, 0); step();
    chk("s32_if", 32'(stall_o), 32'h03);

    // Full fetch window.
    set_in(0, 1, 0, 0, 32'h0, 0, 0, 0, 0); step(); step(); step(); step();
    chk("s33_full", 32'(stall_o), 32'h03);
    step();
    set_in(0, 1, 1, 0, 32'h0, 0, 0, 0, 0); step();
    chk("s33_both", 32'(stall_o), 32'h03);
    set_in(0, 0, 1, 0, 32'h0, 0, 0, 0, 0); step();
    chk("s33_below_full", 32'(stall_o), 32'h00);
    step(); step(); step(); step();

    // Flush beats ack in REDIRECT.
    set_in(0, 0, 0, 1, 32'hBFC00380, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 32'h80001000, 1, 0, 0, 0); step();
    chk("s34_pc", new_pc_o, 32'h80001000);
    chk("s34_flush", 32'(flush_o), 32'h1);
    chk("s34_valid", 32'(redirect_valid_o), 32'h1);
    set_in(0, 0, 0, 0, 32'h0, 1, 0, 0, 0); step();

    // Reset mid-DRAIN.
    set_in(0, 1, 0, 0, 32'h0, 0, 0, 0, 0); step(); step();
    set_in(0, 0, 0, 1, 32'hDEADBEE0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 1, 32'h11111111, 1, 0, 0, 0); step();
    chk("s35_busy", 32'(busy_o), 32'h0);
    chk("s35_pc", new_pc_o, 32'h0);
    chk("s35_flush", 32'(flush_o), 32'h0);
    // Counter must be zero, so a flush now goes straight to REDIRECT.
    set_in(0, 0, 0, 1, 32'h00000040, 0, 0, 0, 0); step();
    chk("s35_cnt_zero", 32'(redirect_valid_o), 32'h1);
    set_in(0, 0, 0, 0, 32'h0, 1, 0, 0, 0); step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, ($urandom_range(0, 11) == 0), $urandom,
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
